// File: rtl/gpio_in_cond_if.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_cond_if
// Description : Bundle of the pad, configuration and conditioned-output
//               signals of the GPIO input-conditioning stage.
//               master : side that drives pads/configuration and consumes
//                        the conditioned outputs (SoC / register block).
//               slave  : the conditioning stage itself (gpio_in_cond).
//   gpio_pad_i   [NO_OF_GPIO_PINS] raw asynchronous pad inputs
//   prescale_i   [PRESC_W]         debounce tick period minus 1
//   db_thresh_i  [CNT_W]           debounce threshold (0 behaves as 1)
//   db_en_i      [NO_OF_GPIO_PINS] per-pin debounce enable
//   rise_en_i    [NO_OF_GPIO_PINS] per-pin rising-edge event enable
//   fall_en_i    [NO_OF_GPIO_PINS] per-pin falling-edge event enable
//   evt_clr_i    [NO_OF_GPIO_PINS] per-pin sticky status clear pulse
//   gpio_filt_o  [NO_OF_GPIO_PINS] conditioned pin levels
//   evt_sts_o    [NO_OF_GPIO_PINS] sticky edge-event status
//   irq_o                          OR of evt_sts_o
// Revision    : 1.0 - initial release
// ============================================================================
interface gpio_in_cond_if #(
    parameter int NO_OF_GPIO_PINS = 24,
    parameter int PRESC_W         = 16,
    parameter int CNT_W           = 4
);
    logic [NO_OF_GPIO_PINS-1:0] gpio_pad_i;
    logic [PRESC_W-1:0]         prescale_i;
    logic [CNT_W-1:0]           db_thresh_i;
    logic [NO_OF_GPIO_PINS-1:0] db_en_i;
    logic [NO_OF_GPIO_PINS-1:0] rise_en_i;
    logic [NO_OF_GPIO_PINS-1:0] fall_en_i;
    logic [NO_OF_GPIO_PINS-1:0] evt_clr_i;
    logic [NO_OF_GPIO_PINS-1:0] gpio_filt_o;
    logic [NO_OF_GPIO_PINS-1:0] evt_sts_o;
    logic                       irq_o;

    modport master (
        output gpio_pad_i, prescale_i, db_thresh_i, db_en_i,
               rise_en_i, fall_en_i, evt_clr_i,
        input  gpio_filt_o, evt_sts_o, irq_o
    );

    modport slave (
        input  gpio_pad_i, prescale_i, db_thresh_i, db_en_i,
               rise_en_i, fall_en_i, evt_clr_i,
        output gpio_filt_o, evt_sts_o, irq_o
    );
endinterface
`default_nettype wire

// File: rtl/gpio_in_cond.sv
`default_nettype none
// ============================================================================
// Module      : gpio_in_cond
// Description : Input conditioning in front of the GPIO register block.
//               Per pin: SYNC_STAGES-deep synchronizer, optional prescaled
//               debounce filter, edge detection with sticky status and a
//               single OR-ed interrupt line.
// Ports       :
//   wb_clk_i   system clock
//   wb_rst_ni  asynchronous active-low reset (release is synchronous to
//              wb_clk_i by the surrounding reset logic)
//   bus        gpio_in_cond_if.slave - pads, configuration, gpio_filt_o,
//              evt_sts_o, irq_o
// Options     : GPIO_IN_COND_IRQ_EN - when defined the edge detector,
//               evt_sts_o and irq_o are built; otherwise evt_sts_o/irq_o
//               are tied to 0 and the event enables/clears are ignored.
// Parameters  : SYNC_STAGES must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_in_cond #(
    parameter int NO_OF_GPIO_PINS = 24,
    parameter int SYNC_STAGES     = 2,
    parameter int PRESC_W         = 16,
    parameter int CNT_W           = 4
) (
    input  wire logic          wb_clk_i,
    input  wire logic          wb_rst_ni,
    gpio_in_cond_if.slave      bus
);

    localparam logic [PRESC_W-1:0] c_PC_INC  = PRESC_W'(1);
    localparam logic [CNT_W-1:0]   c_CNT_INC = CNT_W'(1);
    localparam logic [CNT_W:0]     c_CNT_ONE = (CNT_W+1)'(1);

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [NO_OF_GPIO_PINS-1:0] r_sync [SYNC_STAGES];
    logic [NO_OF_GPIO_PINS-1:0] w_sync_q;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= bus.gpio_pad_i;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce prescaler. The >= compare makes a lowered prescale_i take
    // effect at once instead of waiting for the counter to wrap.
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] r_pc;
    logic               w_tick;

    assign w_tick = (r_pc >= bus.prescale_i);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_pc <= '0;
        end else if (w_tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + c_PC_INC;
        end
    end

    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]           w_thr;
    logic [CNT_W-1:0]           r_cnt [NO_OF_GPIO_PINS];
    logic [NO_OF_GPIO_PINS-1:0] r_filt;

    // A zero threshold behaves as one tick.
    assign w_thr = (bus.db_thresh_i == '0) ? c_CNT_INC : bus.db_thresh_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_filt <= '0;
            for (int p = 0; p < NO_OF_GPIO_PINS; p++) begin
                r_cnt[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NO_OF_GPIO_PINS; p++) begin
                if (!bus.db_en_i[p]) begin
                    // Bypass; any partial count is thrown away.
                    r_filt[p] <= w_sync_q[p];
                    r_cnt[p]  <= '0;
                end else if (w_sync_q[p] == r_filt[p]) begin
                    r_cnt[p] <= '0;
                end else if (w_tick) begin
                    // Compared one bit wider so cnt+1 cannot overflow; the
                    // counter is cleared before it can pass the threshold.
                    if (({1'b0, r_cnt[p]} + c_CNT_ONE) >= {1'b0, w_thr}) begin
                        r_filt[p] <= w_sync_q[p];
                        r_cnt[p]  <= '0;
                    end else begin
                        r_cnt[p] <= r_cnt[p] + c_CNT_INC;
                    end
                end
            end
        end
    end

    assign bus.gpio_filt_o = r_filt;

    // ------------------------------------------------------------------
    // Edge detection and sticky status
    // ------------------------------------------------------------------
`ifdef GPIO_IN_COND_IRQ_EN
    logic [NO_OF_GPIO_PINS-1:0] r_prev;
    logic [NO_OF_GPIO_PINS-1:0] r_evt;
    logic [NO_OF_GPIO_PINS-1:0] w_rise;
    logic [NO_OF_GPIO_PINS-1:0] w_fall;

    assign w_rise =  r_filt & ~r_prev;
    assign w_fall = ~r_filt &  r_prev;

    // New events are OR-ed in after the clear so a set wins a collision.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_prev <= '0;
            r_evt  <= '0;
        end else begin
            r_prev <= r_filt;
            r_evt  <= (r_evt & ~bus.evt_clr_i)
                    | (w_rise & bus.rise_en_i)
                    | (w_fall & bus.fall_en_i);
        end
    end

    assign bus.evt_sts_o = r_evt;
    assign bus.irq_o     = |r_evt;
`else
    logic w_unused_evt_cfg;

    assign w_unused_evt_cfg = ^{bus.rise_en_i, bus.fall_en_i, bus.evt_clr_i};
    assign bus.evt_sts_o    = '0;
    assign bus.irq_o        = 1'b0;
`endif

endmodule
`default_nettype wire
